hex_keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad and turns debounced key presses into hex nibbles. Accepted nibbles shift into a 16-bit entry register, which feeds the 16-bit data input of the board's 4-digit hex display. It is the input-side counterpart of the display scanner: it drives columns and reads rows, where the display drives anodes and cathodes.

---
 rtl/hex_keypad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_hex_keypad_scanner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-sweep results and shifts accepted hex nibbles into a 16-bit
// entry register that drives the 4-digit hex display.
// Optional feature macro: KEY_BACKSPACE_EN (code F removes the newest nibble
// instead of entering it).
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] data
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  logic [3:0]    row_meta, row_sync;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell_cnt;
  logic          dwell_last, sweep_end;

  logic          col_hit;
  logic [1:0]    row_idx;
  logic [3:0]    col_code;
  logic          acc_hit;
  logic [3:0]    acc_code;
  logic          sweep_hit;
  logic [3:0]    sweep_code;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    cand, cand_nxt;
  logic          accept;
  logic [3:0]    accept_code;

  // Two-flop synchronizer for the asynchronous, pulled-up row lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the register order inside the block does not matter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign dwell_last = (dwell_cnt == DWELL_LAST);
  assign sweep_end  = dwell_last && (col_idx == 2'd3);
  assign col        = ~(4'b0001 << col_idx);

  // Column dwell counter and column index; each column is driven SCAN_DIV clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
    end else if (dwell_last) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // Decode the lowest pressed row of the current column, valid on the last dwell clock.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    col_hit = dwell_last;
    row_idx = 2'd0;
    casez (row_sync)
      4'b???0: row_idx = 2'd0;
      4'b??01: row_idx = 2'd1;
      4'b?011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: col_hit = 1'b0;
    endcase
    col_code = {row_idx, col_idx};
  end

  // Fold this column into the running sweep result; the lowest code wins.
  always_comb begin
    sweep_hit  = acc_hit | col_hit;
    sweep_code = acc_code;
    if (col_hit && (!acc_hit || (col_code < acc_code))) begin
      sweep_code = col_code;
    end
  end

  // Sweep accumulator, cleared when the column-3 result is handed to the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_hit  <= 1'b0;
      acc_code <= 4'h0;
    end else if (sweep_end) begin
      acc_hit  <= 1'b0;
      acc_code <= 4'h0;
    end else if (dwell_last) begin
      acc_hit  <= sweep_hit;
      acc_code <= sweep_code;
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // Debounce FSM next state; it only moves on a sweep boundary.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    accept      = 1'b0;
    accept_code = cand;
    if (sweep_end) begin
      case (state)
        IDLE: begin
          if (sweep_hit) begin
            cand_nxt = sweep_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept      = 1'b1;
              accept_code = sweep_code;
              state_nxt   = PRESSED;
              cnt_nxt     = '0;
            end else begin
              state_nxt = DEBOUNCE;
              cnt_nxt   = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (sweep_hit && (sweep_code == cand)) begin
            if ((cnt + CW'(1)) == CNT_DONE) begin
              accept    = 1'b1;
              state_nxt = PRESSED;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        PRESSED: begin
          if (!sweep_hit) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RELEASE;
              cnt_nxt   = CW'(1);
            end
          end
        end
        RELEASE: begin
          if (sweep_hit) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if ((cnt + CW'(1)) == CNT_DONE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Accept pulse, last key code and the entry register; clear wins over entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      data      <= 16'h0000;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= accept_code;
      end
      if (clear) begin
        data <= 16'h0000;
      end else if (accept) begin
`ifdef KEY_BACKSPACE_EN
        if (accept_code == 4'hF) begin
          data <= {4'h0, data[15:4]};
        end else begin
          data <= {data[11:0], accept_code};
        end
`else
        data <= {data[11:0], accept_code};
`endif
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// A keypad model turns the set of held keys into row levels for the driven
// column; stimulus pushes the expected {key_code, data} for each accept and a
// monitor pops and compares whenever key_valid pulses.
module tb_hex_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SWEEP          = 4 * SCAN_DIV;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] data;

  logic [15:0] keys;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hex_keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .clear    (clear),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .data     (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a held key at (r, c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic sweeps(input int n);
    repeat (n * SWEEP) @(negedge clk);
  endtask

  task automatic expect_key(input logic [3:0] code, input logic [15:0] d);
    exp_t e;
    e.code = code;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic press(input int code, input int hold, input int rel);
    keys = 16'h0001 << code;
    sweeps(hold);
    keys = 16'h0000;
    sweeps(rel);
  endtask

  // Monitor: every key_valid pulse must match the oldest expected accept.
  always @(negedge clk) begin
    if (reset && key_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_key_valid", {31'd0, key_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, e.code});
        check("data", {16'd0, data}, {16'd0, e.data});
      end
    end
  end

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    keys  = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_col", {28'd0, col}, 32'hE);
    check("reset_key_valid", {31'd0, key_valid}, 32'd0);
    check("reset_key_code", {28'd0, key_code}, 32'd0);
    check("reset_data", {16'd0, data}, 32'd0);
    reset = 1'b1;

    // 1: idle sweep, column pattern rotates every SCAN_DIV clocks.
    for (int j = 0; j < 4 * SWEEP; j++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((j / SCAN_DIV) % 4));
      check("idle_col", {28'd0, col}, {28'd0, exp_col});
      @(negedge clk);
    end
    check("idle_data", {16'd0, data}, 32'd0);

    // 2: key r=1 c=2 held 5 sweeps gives a single accept.
    expect_key(4'h6, 16'h0006);
    press(6, 5, 3);

    // 3: five keys in turn.
    expect_key(4'h1, 16'h0061);
    press(1, 3, 3);
    expect_key(4'h2, 16'h0612);
    press(2, 3, 3);
    expect_key(4'h3, 16'h6123);
    press(3, 3, 3);
    expect_key(4'h4, 16'h1234);
    press(4, 3, 3);
    expect_key(4'h5, 16'h2345);
    press(5, 3, 3);
    check("after_five_keys", {16'd0, data}, 32'h2345);

    // 4: bouncing press on 9 is rejected, stable press accepted.
    press(9, 1, 1);
    press(9, 1, 2);
    expect_key(4'h9, 16'h3459);
    press(9, 3, 3);

    // 5: keys 0 and 5 together; releasing only 0 must not re-trigger.
    expect_key(4'h0, 16'h4590);
    keys = 16'h0021;
    sweeps(3);
    keys = 16'h0020;
    sweeps(3);
    keys = 16'h0000;
    sweeps(3);
    expect_key(4'h5, 16'h5905);
    press(5, 3, 3);

    // 6: clear in the same clock as the accept of key 7.
    expect_key(4'h7, 16'h0000);
    keys = 16'h0080;
    sweeps(1);
    repeat (SWEEP - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sweeps(1);
    keys = 16'h0000;
    sweeps(3);
    check("after_clear", {16'd0, data}, 32'h0);

    expect_key(4'h1, 16'h0001);
    press(1, 3, 3);
    expect_key(4'h2, 16'h0012);
    press(2, 3, 3);
    expect_key(4'h3, 16'h0123);
    press(3, 3, 3);
    expect_key(4'h4, 16'h1234);
    press(4, 3, 3);
`ifdef KEY_BACKSPACE_EN
    expect_key(4'hF, 16'h0123);
`else
    expect_key(4'hF, 16'h234F);
`endif
    press(15, 3, 3);

    // Reset mid-debounce: everything returns to reset values, no late key.
    keys = 16'h0008;
    sweeps(1);
    repeat (SWEEP / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_col", {28'd0, col}, 32'hE);
    check("midreset_key_valid", {31'd0, key_valid}, 32'd0);
    check("midreset_key_code", {28'd0, key_code}, 32'd0);
    check("midreset_data", {16'd0, data}, 32'd0);
    keys = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sweeps(4);
    expect_key(4'h3, 16'h0003);
    press(3, 3, 3);

    check("pending_accepts", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
